// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the UART boot loader (imem_uart_loader).
//   state_e            : loader FSM states
//   DEFAULT_SYNC_BYTE  : default frame start marker
//   HDR_LEN            : header length in bytes (SYNC, LEN_LO, LEN_HI)
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         HDR_LEN           = 3;

endpackage

// File: rtl/loader_timeout_cnt.sv
// -----------------------------------------------------------------------------
// loader_timeout_cnt
// Idle-cycle counter used by the boot loader to abandon stalled frames.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clr_i     : synchronous clear (has priority over en_i)
//   en_i      : count one cycle
//   expired_o : counter has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module loader_timeout_cnt #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Saturate at the expiry value so a stuck enable cannot wrap the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
// Boot loader: receives a framed byte stream from the UART, assembles
// little-endian 32-bit words, writes them to instruction memory and keeps the
// core in reset until a complete, checksum-valid image has been loaded.
// Frame: SYNC, LEN_LO, LEN_HI, N*4 data bytes (LSB first), CSUM (XOR of data).
//   i_clk        : clock
//   i_rstn       : asynchronous active-low reset
//   i_rx_valid   : byte strobe from UART receiver
//   i_rx_data    : received byte
//   o_imem_we    : instruction memory write strobe (one cycle)
//   o_imem_addr  : byte address of the write
//   o_imem_wdata : write data
//   o_core_rstn  : active-low reset for the core
//   o_busy       : frame in progress
//   o_done       : last frame loaded successfully
//   o_err        : last frame failed
// -----------------------------------------------------------------------------
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH           = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE       = DEFAULT_SYNC_BYTE,
    parameter int          TIMEOUT         = 100000,
    parameter bit          HOLD_UNTIL_LOAD = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_wdata,
    output logic        o_core_rstn,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int          WIDX_W  = $clog2(DEPTH + 1);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_e             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [15:0]        len_q, len_d;
    logic [WIDX_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        asm_q, asm_d;       // lanes 0..2; lane 3 comes straight from the bus
    logic [7:0]         csum_q, csum_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               core_rstn_q, core_rstn_d;

    logic               busy;
    logic               tmo_expired;
    logic [15:0]        frame_len;
    logic               last_word;

    assign busy = (state_q == LEN0) || (state_q == LEN1) ||
                  (state_q == DATA) || (state_q == CSUM);

    // Idle counter: cleared by any accepted byte, and held clear outside a frame.
    loader_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i     (i_clk),
        .rst_ni    (i_rstn),
        .clr_i     (i_rx_valid || !busy),
        .en_i      (busy),
        .expired_o (tmo_expired)
    );

    assign frame_len = {i_rx_data, len_lo_q};
    assign last_word = ((32'(word_idx_q) + 32'd1) == 32'(len_q));

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        core_rstn_d = core_rstn_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    state_d     = LEN0;
                    core_rstn_d = 1'b0;
                end
            end
            LEN0: begin
                if (i_rx_valid) begin
                    len_lo_d = i_rx_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (i_rx_valid) begin
                    if ((frame_len == 16'd0) || (32'(frame_len) > DEPTH_U)) begin
                        state_d = ERR;
                    end else begin
                        len_d      = frame_len;
                        word_idx_d = '0;
                        byte_idx_d = 2'd0;
                        csum_d     = 8'd0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (i_rx_valid) begin
                    csum_d     = csum_q ^ i_rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = i_rx_data;
                        2'd1: asm_d[15:8]  = i_rx_data;
                        2'd2: asm_d[23:16] = i_rx_data;
                        default: begin
                            // Fourth byte: issue the write on the next cycle.
                            we_d       = 1'b1;
                            wdata_d    = {i_rx_data, asm_q};
                            addr_d     = BASE_ADDR + (32'(word_idx_q) << 2);
                            word_idx_d = word_idx_q + WIDX_W'(1);
                            if (last_word) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
            end
            CSUM: begin
                if (i_rx_valid) begin
                    if (i_rx_data == csum_q) begin
                        state_d     = DONE;
                        core_rstn_d = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled frame is abandoned; an arriving byte always wins.
        if (busy && !i_rx_valid && tmo_expired) begin
            state_d     = ERR;
            core_rstn_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            word_idx_q  <= '0;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'd0;
            csum_q      <= 8'd0;
            we_q        <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'd0;
            core_rstn_q <= ~HOLD_UNTIL_LOAD;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            core_rstn_q <= core_rstn_d;
        end
    end

    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_core_rstn  = core_rstn_q;
    assign o_busy       = busy;
    assign o_done       = (state_q == DONE);
    assign o_err        = (state_q == ERR);

endmodule

// File: tb/tb_imem_uart_loader.sv
module tb_imem_uart_loader;

    localparam int          DEPTH   = 4;
    localparam int          TIMEOUT = 20;
    localparam logic [31:0] BASE    = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'd0;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_core_rstn;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    imem_uart_loader #(
        .DEPTH           (DEPTH),
        .BASE_ADDR       (BASE),
        .SYNC_BYTE       (8'hA5),
        .TIMEOUT         (TIMEOUT),
        .HOLD_UNTIL_LOAD (1'b1)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_core_rstn  (o_core_rstn),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
        logic        err;
        logic        crst;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic we,
                                input logic [31:0] a, input logic [31:0] w,
                                input logic b, input logic dn, input logic er,
                                input logic cr);
        vec_t r;
        r.v = v; r.d = d; r.we = we; r.addr = a; r.wdata = w;
        r.busy = b; r.done = dn; r.err = er; r.crst = cr;
        return r;
    endfunction

    // Byte with no write expected.
    function automatic vec_t vb(input logic [7:0] d, input logic b, input logic dn,
                                input logic er, input logic cr);
        return mk(1'b1, d, 1'b0, 32'd0, 32'd0, b, dn, er, cr);
    endfunction

    // Fourth byte of a word mid-frame: write expected next cycle.
    function automatic vec_t vw(input logic [7:0] d, input logic [31:0] a,
                                input logic [31:0] w);
        return mk(1'b1, d, 1'b1, a, w, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic [7:0] d);
        i_rx_valid = v;
        i_rx_data  = d;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic chk_status(input string nm, input logic b, input logic dn,
                              input logic er, input logic cr);
        chk({nm, "_busy"}, {31'd0, o_busy}, {31'd0, b});
        chk({nm, "_done"}, {31'd0, o_done}, {31'd0, dn});
        chk({nm, "_err"},  {31'd0, o_err},  {31'd0, er});
        chk({nm, "_crst"}, {31'd0, o_core_rstn}, {31'd0, cr});
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_we"},    {31'd0, o_imem_we}, 32'd0);
        chk({nm, "_addr"},  o_imem_addr, BASE);
        chk({nm, "_wdata"}, o_imem_wdata, 32'd0);
        chk_status(nm, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0]  bytes_w [4];
        logic [7:0]  cs;
        logic [31:0] w32;

        // ---------------- vector table ----------------
        // leading garbage is ignored
        vq.push_back(vb(8'h00, 0, 0, 0, 0));
        vq.push_back(vb(8'hFF, 0, 0, 0, 0));
        // nominal two-word frame; CSUM = 93^50^13^81^10 = 0x41
        vq.push_back(vb(8'hA5, 1, 0, 0, 0));
        vq.push_back(vb(8'h02, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 1, 0, 0, 0));
        vq.push_back(vb(8'h93, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 1, 0, 0, 0));
        vq.push_back(vb(8'h50, 1, 0, 0, 0));
        vq.push_back(vw(8'h00, 32'h0, 32'h0050_0093));
        vq.push_back(vb(8'h13, 1, 0, 0, 0));
        vq.push_back(vb(8'h81, 1, 0, 0, 0));
        vq.push_back(vb(8'h10, 1, 0, 0, 0));
        vq.push_back(vw(8'h00, 32'h4, 32'h0010_8113));
        vq.push_back(vb(8'h41, 0, 1, 0, 1));
        vq.push_back(mk(1'b0, 8'h00, 0, 0, 0, 0, 1, 0, 1));
        // reload with bad checksum: core drops into reset, writes still happen
        vq.push_back(vb(8'hA5, 1, 0, 0, 0));
        vq.push_back(vb(8'h02, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 1, 0, 0, 0));
        vq.push_back(vb(8'h93, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 1, 0, 0, 0));
        vq.push_back(vb(8'h50, 1, 0, 0, 0));
        vq.push_back(vw(8'h00, 32'h0, 32'h0050_0093));
        vq.push_back(vb(8'h13, 1, 0, 0, 0));
        vq.push_back(vb(8'h81, 1, 0, 0, 0));
        vq.push_back(vb(8'h10, 1, 0, 0, 0));
        vq.push_back(vw(8'h00, 32'h4, 32'h0010_8113));
        vq.push_back(vb(8'h00, 0, 0, 1, 0));
        // sync byte used as payload and as checksum; CSUM = A5^01^02^03 = A5
        vq.push_back(vb(8'hA5, 1, 0, 0, 0));
        vq.push_back(vb(8'h01, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 1, 0, 0, 0));
        vq.push_back(vb(8'hA5, 1, 0, 0, 0));
        vq.push_back(vb(8'h01, 1, 0, 0, 0));
        vq.push_back(vb(8'h02, 1, 0, 0, 0));
        vq.push_back(vw(8'h03, 32'h0, 32'h0302_01A5));
        vq.push_back(vb(8'hA5, 0, 1, 0, 1));
        // N = 0 rejected straight after LEN_HI
        vq.push_back(vb(8'hA5, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 0, 0, 1, 0));
        // N = DEPTH+1 rejected straight after LEN_HI
        vq.push_back(vb(8'hA5, 1, 0, 0, 0));
        vq.push_back(vb(8'h05, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 0, 0, 1, 0));
        // N = DEPTH: bytes 01..10, last write at BASE + 4*(DEPTH-1)
        vq.push_back(vb(8'hA5, 1, 0, 0, 0));
        vq.push_back(vb(8'h04, 1, 0, 0, 0));
        vq.push_back(vb(8'h00, 1, 0, 0, 0));
        cs = 8'h00;
        for (int w = 0; w < DEPTH; w++) begin
            for (int b = 0; b < 4; b++) begin
                bytes_w[b] = 8'(w * 4 + b + 1);
                cs = cs ^ bytes_w[b];
            end
            w32 = {bytes_w[3], bytes_w[2], bytes_w[1], bytes_w[0]};
            for (int b = 0; b < 3; b++) vq.push_back(vb(bytes_w[b], 1, 0, 0, 0));
            vq.push_back(vw(bytes_w[3], BASE + 32'(w * 4), w32));
        end
        vq.push_back(vb(cs, 0, 1, 0, 1));

        // ---------------- reset ----------------
        i_rstn = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk_reset("rst_hold");
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        chk_reset("rst_rel");

        // ---------------- table (bytes back-to-back) ----------------
        foreach (vq[i]) begin
            send(vq[i].v, vq[i].d);
            chk($sformatf("v%0d_we", i), {31'd0, o_imem_we}, {31'd0, vq[i].we});
            if (vq[i].we) begin
                chk($sformatf("v%0d_addr", i), o_imem_addr, vq[i].addr);
                chk($sformatf("v%0d_wdata", i), o_imem_wdata, vq[i].wdata);
            end
            chk_status($sformatf("v%0d", i), vq[i].busy, vq[i].done, vq[i].err, vq[i].crst);
            $display("vec %0d v=%0b d=%h we=%0b addr=%h wdata=%h busy=%0b done=%0b err=%0b crst=%0b",
                     i, vq[i].v, vq[i].d, o_imem_we, o_imem_addr, o_imem_wdata,
                     o_busy, o_done, o_err, o_core_rstn);
        end

        // ---------------- timeout after 5 data bytes ----------------
        send(1'b1, 8'hA5);
        send(1'b1, 8'h02);
        send(1'b1, 8'h00);
        send(1'b1, 8'h93);
        send(1'b1, 8'h00);
        send(1'b1, 8'h50);
        send(1'b1, 8'h00);
        chk("tmo_w0_we", {31'd0, o_imem_we}, 32'd1);
        send(1'b1, 8'h13);
        repeat (TIMEOUT - 1) send(1'b0, 8'h00);
        chk_status("tmo_pre", 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'h00);
        chk_status("tmo_hit", 1'b0, 1'b0, 1'b1, 1'b0);
        $display("timeout busy=%0b err=%0b", o_busy, o_err);
        // fresh frame restarts at BASE; CSUM = DE^AD^BE^EF = 0x22
        send(1'b1, 8'hA5);
        chk_status("tmo_sync", 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 8'h01);
        send(1'b1, 8'h00);
        send(1'b1, 8'hDE);
        send(1'b1, 8'hAD);
        send(1'b1, 8'hBE);
        send(1'b1, 8'hEF);
        chk("tmo_re_we", {31'd0, o_imem_we}, 32'd1);
        chk("tmo_re_addr", o_imem_addr, BASE);
        chk("tmo_re_wdata", o_imem_wdata, 32'hEFBE_ADDE);
        send(1'b1, 8'h22);
        chk_status("tmo_re_done", 1'b0, 1'b1, 0, 1'b1);
        $display("reload after timeout done=%0b crst=%0b", o_done, o_core_rstn);

        // ---------------- asynchronous reset mid-frame ----------------
        send(1'b1, 8'hA5);
        send(1'b1, 8'h03);
        send(1'b1, 8'h00);
        send(1'b1, 8'h11);
        send(1'b1, 8'h22);
        send(1'b1, 8'h33);
        send(1'b1, 8'h44);
        send(1'b1, 8'h55);
        send(1'b1, 8'h66);
        send(1'b1, 8'h77);
        send(1'b1, 8'h88);
        chk("mid_we", {31'd0, o_imem_we}, 32'd1);
        chk("mid_addr", o_imem_addr, BASE + 32'h4);
        chk("mid_wdata", o_imem_wdata, 32'h8877_6655);
        chk_status("mid", 1'b1, 1'b0, 1'b0, 1'b0);
        i_rstn = 1'b0;
        #1;
        chk_reset("async_rst");
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        send(1'b0, 8'h00);
        chk_reset("post_rst");
        // the aborted frame must not continue: a data byte is now ignored
        send(1'b1, 8'h99);
        chk_reset("post_rst_byte");
        $display("reset mid-frame we=%0b busy=%0b crst=%0b", o_imem_we, o_busy, o_core_rstn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
